cu_sequencer: RTL and testbench

Parametrised T-cycle/M-cycle sequencer for the CPU control unit. It drives the step decode that opcode microcode blocks consume, and owns four things: the overlapped opcode fetch, the instruction-register load, interrupt dispatch and the HALT state. Compared with the fixed 4T/8M step clock it adds configurable cycle geometry, prioritised interrupt entry with a vector, HALT wake-up and a runaway-opcode guard.

---
 rtl/cu_sequencer.sv | 150 +++++++++++++++
 tb/tb_cu_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// T-cycle/M-cycle sequencer for the CPU control unit: step decode, overlapped fetch,
// instruction-register load, prioritised interrupt dispatch and HALT handling.
module cu_sequencer #(
  parameter int         T_PER_M      = 4,
  parameter int         MAX_M        = 8,
  parameter int         INT_COUNT    = 5,
  parameter int         INT_M_CYCLES = 5,
  parameter logic [7:0] VECTOR_BASE  = 8'h40
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 i_Enable,
  input  logic                 i_End_Op,
  input  logic                 i_Halt,
  input  logic                 i_IME,
  input  logic [INT_COUNT-1:0] i_Int_Req,
  output logic [T_PER_M-1:0]   o_Step_T,
  output logic [MAX_M-1:0]     o_Cycle_M,
  output logic                 o_Fetch,
  output logic                 o_IR_Write,
  output logic                 o_Int_Active,
  output logic [7:0]           o_Int_Vector,
  output logic [INT_COUNT-1:0] o_Int_Ack,
  output logic                 o_Halted,
  output logic                 o_Overrun
);

  localparam int TW = (T_PER_M > 1) ? $clog2(T_PER_M) : 1;
  localparam int MW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int IW = (INT_COUNT > 1) ? $clog2(INT_COUNT) : 1;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_INT, ST_HALT} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [MW-1:0]  m_q, m_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           overrun_q, overrun_d;

  logic           boundary, int_pend, int_take, m_last, int_last, exec_reload;
  logic [IW-1:0]  req_idx;
  logic [7:0]     idx_off;

  assign boundary = i_Enable && (t_q == TW'(T_PER_M - 1));
  assign int_pend = |i_Int_Req;
  assign int_take = i_IME && int_pend;
  assign m_last   = (m_q == MW'(MAX_M - 1));
  assign int_last = (m_q == MW'(INT_M_CYCLES - 1));

  // An opcode that never raises i_End_Op is closed out at its last M-cycle like a normal end.
  assign exec_reload = i_End_Op ? (!int_take && !i_Halt) : m_last;

  // Lowest set request index wins; scanning downwards lets the lowest index overwrite.
  always_comb begin
    req_idx = '0;
    for (int i = INT_COUNT - 1; i >= 0; i--) begin
      if (i_Int_Req[i]) req_idx = IW'(i);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    t_d       = t_q;
    m_d       = m_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;

    if (i_Enable && state_q != ST_HALT) begin
      if (boundary) begin
        t_d = '0;
        m_d = m_q + 1'b1;
      end else begin
        t_d = t_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_FETCH: if (boundary) begin
        state_d = ST_EXEC;
        m_d     = '0;
      end
      ST_EXEC: if (boundary) begin
        if (i_End_Op && int_take) begin
          state_d = ST_INT;
          m_d     = '0;
          idx_d   = req_idx;
        end else if (i_End_Op && i_Halt) begin
          state_d = ST_HALT;
          m_d     = '0;
        end else if (i_End_Op) begin
          m_d = '0;
        end else if (m_last) begin
          overrun_d = 1'b1;
          m_d       = '0;
        end
      end
      ST_INT: if (boundary && int_last) begin
        state_d = ST_FETCH;
        m_d     = '0;
      end
      ST_HALT: begin
        t_d = '0;
        m_d = '0;
        // Wake-up is immediate on any enabled clock; it does not wait for a T boundary.
        if (i_Enable && int_pend) begin
          if (i_IME) begin
            state_d = ST_INT;
            idx_d   = req_idx;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_Reset_n) begin
      state_q   <= ST_FETCH;
      t_q       <= '0;
      m_q       <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      m_q       <= m_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign idx_off = 8'(idx_q);

  assign o_Step_T     = (state_q == ST_HALT) ? '0 : (T_PER_M'(1) << t_q);
  assign o_Cycle_M    = (state_q == ST_EXEC || state_q == ST_INT) ? (MAX_M'(1) << m_q) : '0;
  assign o_Fetch      = (state_q == ST_FETCH) ||
                        (state_q == ST_EXEC && (i_End_Op ? !int_take : m_last));
  assign o_IR_Write   = boundary && ((state_q == ST_FETCH) || (state_q == ST_EXEC && exec_reload));
  assign o_Int_Active = (state_q == ST_INT);
  assign o_Int_Vector = VECTOR_BASE + (idx_off << 3);
  assign o_Int_Ack    = (state_q == ST_INT && m_q == '0 && t_q == '0 && i_Enable) ?
                        (INT_COUNT'(1) << idx_q) : '0;
  assign o_Halted     = (state_q == ST_HALT);
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer at default geometry (4T/8M, 5 interrupts, 5-M dispatch).
module tb_cu_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n, i_Enable, i_End_Op, i_Halt, i_IME;
  logic [4:0] i_Int_Req;
  logic [3:0] o_Step_T;
  logic [7:0] o_Cycle_M;
  logic       o_Fetch, o_IR_Write, o_Int_Active, o_Halted, o_Overrun;
  logic [7:0] o_Int_Vector;
  logic [4:0] o_Int_Ack;

  int total = 0;
  int bad   = 0;

  cu_sequencer dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Enable(i_Enable), .i_End_Op(i_End_Op),
    .i_Halt(i_Halt), .i_IME(i_IME), .i_Int_Req(i_Int_Req),
    .o_Step_T(o_Step_T), .o_Cycle_M(o_Cycle_M), .o_Fetch(o_Fetch), .o_IR_Write(o_IR_Write),
    .o_Int_Active(o_Int_Active), .o_Int_Vector(o_Int_Vector), .o_Int_Ack(o_Int_Ack),
    .o_Halted(o_Halted), .o_Overrun(o_Overrun)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge; outputs are then sampled 1 time unit later, away from the edge.
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Reset_n = 1'b0;
    step();
    i_Reset_n = 1'b1;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_step_t"}, o_Step_T, 4'b0001);
    check({tag, "_fetch"}, o_Fetch, 1'b1);
    check({tag, "_cycle_m"}, o_Cycle_M, 8'h00);
    check({tag, "_ir_write"}, o_IR_Write, 1'b0);
    check({tag, "_int_active"}, o_Int_Active, 1'b0);
    check({tag, "_vector"}, o_Int_Vector, 8'h40);
    check({tag, "_ack"}, o_Int_Ack, 5'b00000);
    check({tag, "_halted"}, o_Halted, 1'b0);
    check({tag, "_overrun"}, o_Overrun, 1'b0);
  endtask

  task automatic run_fetch();
    i_End_Op = 1'b0;
    i_Halt   = 1'b0;
    for (int t = 0; t < 4; t++) step();
    check("fetch_to_exec_cycle_m", o_Cycle_M, 8'h01);
  endtask

  initial begin
    i_Reset_n = 1'b1; i_Enable = 1'b0; i_End_Op = 1'b0; i_Halt = 1'b0;
    i_IME = 1'b0; i_Int_Req = '0;
    #2;

    // Reset with enable low still clears everything.
    do_reset();
    check_reset_state("rst0");

    // Standalone fetch: T walks 1,2,4,8; IR load only at the boundary.
    i_Enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("fetch_step_t", o_Step_T, 32'(1 << t));
      check("fetch_fetch", o_Fetch, 1'b1);
      check("fetch_ir_write", o_IR_Write, t == 3);
      step();
    end
    check("exec_cycle_m0", o_Cycle_M, 8'h01);
    check("exec_fetch_idle", o_Fetch, 1'b0);

    // Three-M opcode ending in M=2: overlapped fetch only during the last M-cycle.
    for (int m = 0; m < 3; m++) begin
      for (int t = 0; t < 4; t++) begin
        i_End_Op = (m == 2);
        #1;
        check("op3_cycle_m", o_Cycle_M, 32'(1 << m));
        check("op3_step_t", o_Step_T, 32'(1 << t));
        check("op3_fetch", o_Fetch, m == 2);
        check("op3_ir_write", o_IR_Write, (m == 2) && (t == 3));
        step();
      end
    end
    i_End_Op = 1'b0;
    #1;
    check("op3_next_m0", o_Cycle_M, 8'h01);
    check("op3_next_t0", o_Step_T, 4'b0001);

    // One-M opcode ending with requests 5'b10100 pending: index 2 wins.
    i_End_Op = 1'b1; i_IME = 1'b1; i_Int_Req = 5'b10100;
    for (int t = 0; t < 3; t++) begin
      #1;
      check("int_entry_fetch_suppressed", o_Fetch, 1'b0);
      step();
    end
    i_Enable = 1'b0;
    #1;
    check("int_entry_stalled_ir", o_IR_Write, 1'b0);
    step();
    check("int_entry_frozen_active", o_Int_Active, 1'b0);
    check("int_entry_frozen_t", o_Step_T, 4'b1000);
    i_Enable = 1'b1;
    #1;
    check("int_entry_ir_write", o_IR_Write, 1'b0);
    step();
    check("int_active_start", o_Int_Active, 1'b1);
    i_End_Op = 1'b0;
    i_Enable = 1'b0;
    #1;
    check("int_ack_deferred", o_Int_Ack, 5'b00000);
    step();
    check("int_stall_t", o_Step_T, 4'b0001);
    check("int_stall_m", o_Cycle_M, 8'h01);
    i_Enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("int_active", o_Int_Active, 1'b1);
      check("int_vector", o_Int_Vector, 8'h50);
      if (k == 0) check("int_ack_pulse", o_Int_Ack, 5'b00100);
      if (k == 1) begin
        check("int_ack_single", o_Int_Ack, 5'b00000);
        i_Int_Req = 5'b00001;
        i_IME     = 1'b0;
      end
      step();
    end
    check("int_exit_active", o_Int_Active, 1'b0);
    check("int_exit_fetch", o_Fetch, 1'b1);
    check("int_exit_cycle_m", o_Cycle_M, 8'h00);
    i_Int_Req = '0;
    run_fetch();

    // HALT entry, stall in HALT, then wake with IME=0 into FETCH.
    i_End_Op = 1'b1; i_Halt = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("halt_op_fetch", o_Fetch, 1'b1);
      check("halt_op_ir_write", o_IR_Write, 1'b0);
      step();
    end
    i_End_Op = 1'b0; i_Halt = 1'b0;
    check("halted", o_Halted, 1'b1);
    check("halted_step_t", o_Step_T, 4'b0000);
    check("halted_cycle_m", o_Cycle_M, 8'h00);
    step();
    check("halt_no_req", o_Halted, 1'b1);
    i_Enable = 1'b0; i_Int_Req = 5'b00001;
    step();
    check("halt_disabled_wake", o_Halted, 1'b1);
    i_Enable = 1'b1;
    step();
    check("wake_fetch_halted", o_Halted, 1'b0);
    check("wake_fetch_fetch", o_Fetch, 1'b1);
    check("wake_fetch_int_active", o_Int_Active, 1'b0);
    check("wake_fetch_ack", o_Int_Ack, 5'b00000);
    i_Int_Req = '0;
    run_fetch();

    // HALT again, then wake with IME=1 into INT at vector 0x40.
    i_End_Op = 1'b1; i_Halt = 1'b1;
    for (int t = 0; t < 4; t++) step();
    i_End_Op = 1'b0; i_Halt = 1'b0;
    check("halted_again", o_Halted, 1'b1);
    i_Int_Req = 5'b00001; i_IME = 1'b1;
    step();
    check("wake_int_active", o_Int_Active, 1'b1);
    check("wake_int_vector", o_Int_Vector, 8'h40);
    check("wake_int_ack", o_Int_Ack, 5'b00001);
    i_Int_Req = '0; i_IME = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("int_m2", o_Cycle_M, 8'h04);

    // Reset in INT M=2 abandons dispatch.
    do_reset();
    check_reset_state("rst_int");

    // End, halt, IME and a request together: INT wins.
    run_fetch();
    i_End_Op = 1'b1; i_Halt = 1'b1; i_IME = 1'b1; i_Int_Req = 5'b00010;
    for (int t = 0; t < 4; t++) step();
    i_End_Op = 1'b0; i_Halt = 1'b0; i_IME = 1'b0; i_Int_Req = '0;
    check("simul_int_active", o_Int_Active, 1'b1);
    check("simul_not_halted", o_Halted, 1'b0);
    check("simul_vector", o_Int_Vector, 8'h48);
    check("simul_ack", o_Int_Ack, 5'b00010);
    do_reset();

    // Runaway opcode: no end flag for 8 M-cycles.
    run_fetch();
    for (int m = 0; m < 8; m++) begin
      for (int t = 0; t < 4; t++) begin
        #1;
        check("runaway_fetch", o_Fetch, m == 7);
        check("runaway_ir_write", o_IR_Write, (m == 7) && (t == 3));
        check("runaway_overrun_clear", o_Overrun, 1'b0);
        step();
      end
    end
    check("overrun_set", o_Overrun, 1'b1);
    check("overrun_next_m0", o_Cycle_M, 8'h01);
    i_End_Op = 1'b1;
    for (int t = 0; t < 4; t++) step();
    i_End_Op = 1'b0;
    check("overrun_sticky", o_Overrun, 1'b1);
    do_reset();
    check("overrun_cleared", o_Overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
